// File: rtl/controlador_sram_pkg.sv
// Shared types and sizes for the SRAM controller: FSM encoding and bus widths.
package controlador_sram_pkg;

    localparam int unsigned BEATS  = 4;
    localparam int unsigned DQ_W   = 16;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned DIR_W  = 18;
    localparam int unsigned ADDR_W = DIR_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ADDR,
        RD_WAIT,
        DONE
    } estado_t;

endpackage

// File: rtl/controlador_sram_if.sv
// Request/response handshake plus the external SRAM pins, grouped as one bus.
interface controlador_sram_if;
    import controlador_sram_pkg::*;

    logic                leer;
    logic                escribir;
    logic [DIR_W-1:0]    direccion_memoria;
    logic [WORD_W-1:0]   datos_por_escribir;
    logic                operacion_completada;
    logic [WORD_W-1:0]   datos_leidos;
    logic                ocupado;

    logic [ADDR_W-1:0]   sram_addr;
    logic [DQ_W-1:0]     sram_dq_o;
    logic [DQ_W-1:0]     sram_dq_i;
    logic                sram_dq_oe;
    logic                sram_ce_n;
    logic                sram_oe_n;
    logic                sram_we_n;
    logic                sram_lb_n;
    logic                sram_ub_n;

    modport master (
        output leer, escribir, direccion_memoria, datos_por_escribir, sram_dq_i,
        input  operacion_completada, datos_leidos, ocupado,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );

    modport slave (
        input  leer, escribir, direccion_memoria, datos_por_escribir, sram_dq_i,
        output operacion_completada, datos_leidos, ocupado,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );

endinterface

// File: rtl/controlador_sram.sv
// Serialises 64-bit read/write requests into four 16-bit asynchronous SRAM accesses.
module controlador_sram
    import controlador_sram_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned RD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    controlador_sram_if.slave  bus
);

    localparam int unsigned MAX_CYC = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

    estado_t             state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIR_W-1:0]    addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   rd_buf_q;
    logic                capture;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.escribir) begin
                    state_d = WR_SETUP;
                    addr_d  = bus.direccion_memoria;
                    data_d  = bus.datos_por_escribir;
                    beat_d  = 2'd0;
                end else if (bus.leer) begin
                    state_d = RD_ADDR;
                    addr_d  = bus.direccion_memoria;
                    beat_d  = 2'd0;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt_q == WE_LAST) state_d = WR_HOLD;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            WR_HOLD: begin
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = WR_SETUP;
                    beat_d  = beat_q + 2'd1;
                end
            end
            RD_ADDR: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    capture = 1'b1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ADDR;
                        beat_d  = beat_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are registered from the next-state view so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q                  <= IDLE;
            beat_q                   <= '0;
            cnt_q                    <= '0;
            addr_q                   <= '0;
            data_q                   <= '0;
            rd_buf_q                 <= '0;
            bus.sram_addr            <= '0;
            bus.sram_dq_o            <= '0;
            bus.sram_dq_oe           <= 1'b0;
            bus.sram_ce_n            <= 1'b1;
            bus.sram_oe_n            <= 1'b1;
            bus.sram_we_n            <= 1'b1;
            bus.sram_lb_n            <= 1'b1;
            bus.sram_ub_n            <= 1'b1;
            bus.operacion_completada <= 1'b0;
            bus.ocupado              <= 1'b0;
            bus.datos_leidos         <= '0;
        end else begin
            state_q                  <= state_d;
            beat_q                   <= beat_d;
            cnt_q                    <= cnt_d;
            addr_q                   <= addr_d;
            data_q                   <= data_d;
            bus.sram_addr            <= {addr_d, beat_d};
            bus.sram_dq_o            <= data_d[{beat_d, 4'b0000} +: DQ_W];
            bus.sram_dq_oe           <= state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
            bus.sram_we_n            <= (state_d != WR_PULSE);
            bus.sram_oe_n            <= !(state_d inside {RD_ADDR, RD_WAIT});
            bus.sram_ce_n            <= (state_d == IDLE);
            bus.sram_lb_n            <= (state_d == IDLE);
            bus.sram_ub_n            <= (state_d == IDLE);
            bus.operacion_completada <= (state_d == DONE);
            bus.ocupado              <= (state_d != IDLE);
            if (capture) begin
                rd_buf_q[{beat_q, 4'b0000} +: DQ_W] <= bus.sram_dq_i;
                if (beat_q == 2'd3)
                    bus.datos_leidos <= {bus.sram_dq_i, rd_buf_q[47:0]};
            end
        end
    end

endmodule

// File: tb/tb_controlador_sram.sv
// Directed bench for controlador_sram with a behavioural asynchronous SRAM model.
module tb_controlador_sram;
    import controlador_sram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controlador_sram_if sif ();

    controlador_sram #(.WE_CYCLES(2), .RD_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int unsigned checks = 0;
    int unsigned passed = 0;
    int          cyc = 0;

    logic [15:0] mem [logic [19:0]];
    logic [19:0] tr_addr [$];
    logic [15:0] tr_data [$];
    int          we_runs [$];
    int          we_run = 0;
    int          done_cnt = 0;
    int          oe_low_cnt = 0;
    int          dqoe_cnt = 0;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] rd_model(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a[15:0];
    endfunction

    // A write lands when we_n rises; the reset-driven rise is not a real write.
    always @(posedge sif.sram_we_n) begin
        if (reset === 1'b1) begin
            tr_addr.push_back(sif.sram_addr);
            tr_data.push_back(sif.sram_dq_o);
            mem[sif.sram_addr] = sif.sram_dq_o;
        end
    end

    always @(negedge clk) begin
        if (sif.operacion_completada === 1'b1) done_cnt++;
        if (sif.sram_we_n === 1'b0) we_run++;
        else if (we_run != 0) begin
            we_runs.push_back(we_run);
            we_run = 0;
        end
        if (sif.sram_oe_n === 1'b0) oe_low_cnt++;
        if (sif.sram_dq_oe === 1'b1) dqoe_cnt++;
        sif.sram_dq_i <= (sif.sram_oe_n === 1'b0) ? rd_model(sif.sram_addr) : 16'h0000;
    end

    task automatic clear_mon();
        tr_addr.delete();
        tr_data.delete();
        we_runs.delete();
        we_run     = 0;
        done_cnt   = 0;
        oe_low_cnt = 0;
        dqoe_cnt   = 0;
    endtask

    task automatic issue(input logic l, input logic e, input logic [17:0] a,
                         input logic [63:0] d, output int k);
        @(posedge clk); #1;
        sif.leer = l;
        sif.escribir = e;
        sif.direccion_memoria = a;
        sif.datos_por_escribir = d;
        @(posedge clk); #1;
        k = cyc;
        sif.leer = 1'b0;
        sif.escribir = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output bit ok);
        ok = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sif.operacion_completada === 1'b1) begin
                ok = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n, sif.sram_lb_n, sif.sram_ub_n} !== 5'b11111)
            $display("FAIL reset_strobes got %b want 11111",
                     {sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n, sif.sram_lb_n, sif.sram_ub_n});
        else passed++;
        checks++;
        if (sif.sram_dq_oe !== 1'b0) $display("FAIL reset_dq_oe got %b want 0", sif.sram_dq_oe);
        else passed++;
        checks++;
        if (sif.sram_addr !== 20'h0) $display("FAIL reset_addr got %h want 00000", sif.sram_addr);
        else passed++;
        checks++;
        if (sif.sram_dq_o !== 16'h0) $display("FAIL reset_dq_o got %h want 0000", sif.sram_dq_o);
        else passed++;
        checks++;
        if (sif.operacion_completada !== 1'b0) $display("FAIL reset_done got %b want 0", sif.operacion_completada);
        else passed++;
        checks++;
        if (sif.ocupado !== 1'b0) $display("FAIL reset_ocupado got %b want 0", sif.ocupado);
        else passed++;
        checks++;
        if (sif.datos_leidos !== 64'h0) $display("FAIL reset_datos got %h want 0", sif.datos_leidos);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write();
        logic [19:0] ea [4] = '{20'h00014, 20'h00015, 20'h00016, 20'h00017};
        logic [15:0] ed [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        int k, dc;
        bit ok;
        clear_mon();
        issue(1'b0, 1'b1, 18'h00005, 64'h0123_4567_89AB_CDEF, k);
        checks++;
        if (sif.ocupado !== 1'b1) $display("FAIL wr_ocupado_start got %b want 1", sif.ocupado);
        else passed++;
        wait_done(dc, ok);
        checks++;
        if (!ok || dc - k != 16) $display("FAIL wr_latency got ok=%0d lat=%0d want 16", ok, dc - k);
        else passed++;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != 1) $display("FAIL wr_done_width got %0d want 1", done_cnt);
        else passed++;
        checks++;
        if (tr_addr.size() != 4) $display("FAIL wr_trace_len got %0d want 4", tr_addr.size());
        else passed++;
        for (int i = 0; i < 4 && i < tr_addr.size(); i++) begin
            checks++;
            if (tr_addr[i] !== ea[i] || tr_data[i] !== ed[i])
                $display("FAIL wr_beat%0d got %h=%h want %h=%h", i, tr_addr[i], tr_data[i], ea[i], ed[i]);
            else passed++;
        end
        checks++;
        if (we_runs.size() != 4 || we_runs[0] != 2 || we_runs[1] != 2 || we_runs[2] != 2 || we_runs[3] != 2)
            $display("FAIL wr_we_pulse got runs=%0d first=%0d want 4 runs of 2",
                     we_runs.size(), (we_runs.size() > 0) ? we_runs[0] : 0);
        else passed++;
        checks++;
        if (sif.ocupado !== 1'b0) $display("FAIL wr_ocupado_end got %b want 0", sif.ocupado);
        else passed++;
    endtask

    task automatic test_read();
        int k, dc;
        bit ok;
        clear_mon();
        issue(1'b1, 1'b0, 18'h00005, 64'h0, k);
        wait_done(dc, ok);
        checks++;
        if (!ok || dc - k != 12) $display("FAIL rd_latency got ok=%0d lat=%0d want 12", ok, dc - k);
        else passed++;
        checks++;
        if (sif.datos_leidos !== 64'h0123_4567_89AB_CDEF)
            $display("FAIL rd_data got %h want 0123456789abcdef", sif.datos_leidos);
        else passed++;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dqoe_cnt != 0) $display("FAIL rd_dq_oe got %0d cycles want 0", dqoe_cnt);
        else passed++;
        checks++;
        if (oe_low_cnt != 12) $display("FAIL rd_oe_cycles got %0d want 12", oe_low_cnt);
        else passed++;
        checks++;
        if (tr_addr.size() != 0) $display("FAIL rd_no_write got %0d want 0", tr_addr.size());
        else passed++;
    endtask

    task automatic test_both();
        int k, dc;
        bit ok;
        clear_mon();
        issue(1'b1, 1'b1, 18'h3FFFF, 64'hFFFF_0000_AAAA_5555, k);
        wait_done(dc, ok);
        checks++;
        if (!ok || dc - k != 16) $display("FAIL both_latency got ok=%0d lat=%0d want 16", ok, dc - k);
        else passed++;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (tr_addr.size() != 4 || tr_addr[0] !== 20'hFFFFC || tr_data[0] !== 16'h5555)
            $display("FAIL both_first_beat got n=%0d want 4 with FFFFC=5555", tr_addr.size());
        else passed++;
        checks++;
        if (tr_addr.size() != 4 || tr_addr[3] !== 20'hFFFFF || tr_data[3] !== 16'hFFFF)
            $display("FAIL both_last_beat got n=%0d want 4 with FFFFF=FFFF", tr_addr.size());
        else passed++;
        checks++;
        if (oe_low_cnt != 0) $display("FAIL both_no_read got %0d oe cycles want 0", oe_low_cnt);
        else passed++;
        checks++;
        if (sif.datos_leidos !== 64'h0123_4567_89AB_CDEF)
            $display("FAIL both_datos_kept got %h want 0123456789abcdef", sif.datos_leidos);
        else passed++;
    endtask

    task automatic test_ignore();
        int k, dc;
        bit ok;
        clear_mon();
        issue(1'b0, 1'b1, 18'h00100, 64'h1111_2222_3333_4444, k);
        repeat (3) @(posedge clk);
        #1;
        sif.leer = 1'b1;
        sif.direccion_memoria = 18'h00200;
        @(posedge clk); #1;
        sif.leer = 1'b0;
        wait_done(dc, ok);
        checks++;
        if (!ok || dc - k != 16) $display("FAIL ign_latency got ok=%0d lat=%0d want 16", ok, dc - k);
        else passed++;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != 1) $display("FAIL ign_done_count got %0d want 1", done_cnt);
        else passed++;
        checks++;
        if (tr_addr.size() != 4 || tr_addr[0] !== 20'h00400 || tr_data[3] !== 16'h1111)
            $display("FAIL ign_trace got n=%0d want 4 starting at 00400", tr_addr.size());
        else passed++;
        checks++;
        if (oe_low_cnt != 0) $display("FAIL ign_no_read got %0d oe cycles want 0", oe_low_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int k, dc;
        bit ok, found;
        clear_mon();
        issue(1'b0, 1'b1, 18'h00020, 64'hDEAD_BEEF_CAFE_F00D, k);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sif.sram_addr === 20'h00082 && sif.sram_we_n === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) $display("FAIL rst_find_beat2 got none want WR_PULSE at 00082");
        else passed++;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (sif.sram_we_n !== 1'b1 || sif.sram_dq_oe !== 1'b0)
            $display("FAIL rst_abort_pins got we_n=%b dq_oe=%b want 1 0", sif.sram_we_n, sif.sram_dq_oe);
        else passed++;
        checks++;
        if (sif.ocupado !== 1'b0 || sif.datos_leidos !== 64'h0)
            $display("FAIL rst_abort_state got ocupado=%b datos=%h want 0 0", sif.ocupado, sif.datos_leidos);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != 0) $display("FAIL rst_no_done got %0d want 0", done_cnt);
        else passed++;
        checks++;
        if (tr_addr.size() != 2) $display("FAIL rst_trace got %0d want 2", tr_addr.size());
        else passed++;
        issue(1'b1, 1'b0, 18'h00000, 64'h0, k);
        wait_done(dc, ok);
        checks++;
        if (!ok || dc - k != 12) $display("FAIL rst_read_latency got ok=%0d lat=%0d want 12", ok, dc - k);
        else passed++;
        checks++;
        if (sif.datos_leidos !== 64'hFFFC_FFFD_FFFE_FFFF)
            $display("FAIL rst_read_data got %h want fffcfffdfffeffff", sif.datos_leidos);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int k, dc, bad;
        bit ok;
        issue(1'b0, 1'b1, 18'h00030, 64'h7, k);
        wait_done(dc, ok);
        issue(1'b1, 1'b0, 18'h00030, 64'h0, k);
        wait_done(dc, ok);
        checks++;
        if (!ok || sif.datos_leidos !== 64'h7) $display("FAIL b2b_seed got %h want 7", sif.datos_leidos);
        else passed++;
        bad = 0;
        ok = 1'b0;
        issue(1'b0, 1'b1, 18'h00031, 64'h5A5A_A5A5_1234_8765, k);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sif.datos_leidos !== 64'h7) bad++;
            if (sif.operacion_completada === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || bad != 0) $display("FAIL b2b_hold_on_write got ok=%0d bad=%0d want 1 0", ok, bad);
        else passed++;
        bad = 0;
        ok = 1'b0;
        issue(1'b1, 1'b0, 18'h00031, 64'h0, k);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sif.operacion_completada === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (sif.datos_leidos !== 64'h7) bad++;
        end
        checks++;
        if (!ok || bad != 0) $display("FAIL b2b_hold_on_read got ok=%0d bad=%0d want 1 0", ok, bad);
        else passed++;
        checks++;
        if (sif.datos_leidos !== 64'h5A5A_A5A5_1234_8765)
            $display("FAIL b2b_read_data got %h want 5a5aa5a512348765", sif.datos_leidos);
        else passed++;
    endtask

    initial begin
        sif.leer = 1'b0;
        sif.escribir = 1'b0;
        sif.direccion_memoria = '0;
        sif.datos_por_escribir = '0;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
